// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the macroblock fetch unit
package fetch_pkg;
    localparam int Y_WORDS  = 64;
    localparam int C_WORDS  = 16;
    localparam int MB_WORDS = 96;
    localparam int U_BASE   = 64;
    localparam int V_BASE   = 80;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} fetch_state_t;
    typedef logic [7:0] pix_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: request, frame-memory read and pixel-matrix bundle of the fetch unit
interface fetch_if;
    import fetch_pkg::*;
    logic [5:0]               fetch_mb_x_i;
    logic [5:0]               fetch_mb_y_i;
    logic                     fetch_start_i;
    logic [31:0]              data_word_i;
    logic                     data_valid_i;
    logic [31:0]              fetch_addr_o;
    pix_t [0:15][0:15]        matrixY_o;
    pix_t [0:7][0:7]          matrixU_o;
    pix_t [0:7][0:7]          matrixV_o;
    logic                     fetch_finish_o;
    modport master (
        output fetch_mb_x_i, fetch_mb_y_i, fetch_start_i, data_word_i, data_valid_i,
        input  fetch_addr_o, matrixY_o, matrixU_o, matrixV_o, fetch_finish_o
    );
    modport slave (
        input  fetch_mb_x_i, fetch_mb_y_i, fetch_start_i, data_word_i, data_valid_i,
        output fetch_addr_o, matrixY_o, matrixU_o, matrixV_o, fetch_finish_o
    );
endinterface

// File: rtl/fetch_addr_gen.sv
// fetch_addr_gen: macroblock base address and word counter forming the memory address
module fetch_addr_gen
    import fetch_pkg::*;
#(
    parameter int FRAME_MB_W = 22
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        inc_i,
    input  logic        clr_i,
    input  logic [5:0]  mb_x_i,
    input  logic [5:0]  mb_y_i,
    output logic [6:0]  cnt_o,
    output logic [31:0] addr_o
);
    logic [31:0] base_q, base_d;
    logic [6:0]  cnt_q, cnt_d;
    always_comb begin
        base_d = load_i ? (32'(mb_y_i) * 32'(FRAME_MB_W) + 32'(mb_x_i)) * 32'(MB_WORDS) : base_q;
        cnt_d  = (load_i || clr_i) ? 7'd0 : inc_i ? cnt_q + 7'd1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
        end
    end
    assign cnt_o  = cnt_q;
    assign addr_o = base_q + 32'(cnt_q);
endmodule

// File: rtl/fetch.sv
// fetch: reads one 4:2:0 macroblock from frame memory and unpacks it into Y/U/V pixel matrices
module fetch
    import fetch_pkg::*;
#(
    parameter int FRAME_MB_W = 22
) (
    input logic   clk,
    input logic   rst,
    fetch_if.slave bus
);
    fetch_state_t      state_q, state_d;
    logic [6:0]        cnt;
    logic              start, wr, last;
    logic [3:0]        ku, kv;
    pix_t [0:15][0:15] y_q, y_d;
    pix_t [0:7][0:7]   u_q, u_d, v_q, v_d;
    assign start = state_q == IDLE && bus.fetch_start_i;
    assign wr    = state_q == LOAD && bus.data_valid_i;
    assign last  = wr && cnt == 7'(MB_WORDS - 1);
    assign ku    = 4'(cnt - 7'(U_BASE));
    assign kv    = 4'(cnt - 7'(V_BASE));
    fetch_addr_gen #(.FRAME_MB_W(FRAME_MB_W)) u_addr (
        .clk    (clk),
        .rst    (rst),
        .load_i (start),
        .inc_i  (wr),
        .clr_i  (last),
        .mb_x_i (bus.fetch_mb_x_i),
        .mb_y_i (bus.fetch_mb_y_i),
        .cnt_o  (cnt),
        .addr_o (bus.fetch_addr_o)
    );
    always_comb begin
        state_d = start ? LOAD : last ? DONE : state_q == DONE ? IDLE : state_q;
    end
    // Each word carries four horizontally adjacent pixels, byte 0 leftmost
    always_comb begin
        y_d = y_q;
        u_d = u_q;
        v_d = v_q;
        for (int b = 0; b < 4; b++) begin
            if (wr && cnt < 7'(Y_WORDS))
                y_d[cnt[5:2]][{cnt[1:0], 2'(b)}] = bus.data_word_i[8*b +: 8];
            else if (wr && cnt < 7'(U_BASE + C_WORDS))
                u_d[ku[3:1]][{ku[0], 2'(b)}] = bus.data_word_i[8*b +: 8];
            else if (wr)
                v_d[kv[3:1]][{kv[0], 2'(b)}] = bus.data_word_i[8*b +: 8];
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            u_q     <= u_d;
            v_q     <= v_d;
        end
    end
    assign bus.matrixY_o      = y_q;
    assign bus.matrixU_o      = u_q;
    assign bus.matrixV_o      = v_q;
    assign bus.fetch_finish_o = state_q == DONE;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed checks of macroblock fetch addressing, unpacking, stalls, relaunch and reset
module tb_fetch;
    import fetch_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    fetch_if bus ();
    fetch #(.FRAME_MB_W(22)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // Memory model: word at address A holds bytes 4A..4A+3 (mod 256), byte 0 lowest
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] p;
        p = {a[5:0], 2'b00};
        return {p + 8'd3, p + 8'd2, p + 8'd1, p};
    endfunction
    assign bus.data_word_i = bus.data_valid_i ? mem_word(bus.fetch_addr_o) : 32'hDEADBEEF;

    function automatic logic [31:0] ypix(input int r, input int c);
        return {bus.matrixY_o[r][c+3], bus.matrixY_o[r][c+2], bus.matrixY_o[r][c+1], bus.matrixY_o[r][c]};
    endfunction
    function automatic logic [31:0] upix(input int r, input int c);
        return {bus.matrixU_o[r][c+3], bus.matrixU_o[r][c+2], bus.matrixU_o[r][c+1], bus.matrixU_o[r][c]};
    endfunction
    function automatic logic [31:0] vpix(input int r, input int c);
        return {bus.matrixV_o[r][c+3], bus.matrixV_o[r][c+2], bus.matrixV_o[r][c+1], bus.matrixV_o[r][c]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called with start already high in IDLE; returns in the DONE cycle
    task automatic run(input logic [31:0] base, input int stall_at, input int stall_len, input bit hold);
        tick();
        bus.fetch_mb_x_i = 6'd63;
        bus.fetch_mb_y_i = 6'd63;
        if (!hold) bus.fetch_start_i = 1'b0;
        for (int k = 0; k < 96; k++) begin
            if (k == stall_at) begin
                bus.data_valid_i = 1'b0;
                repeat (stall_len) begin
                    chk("stall_addr", bus.fetch_addr_o, base + 32'(k));
                    chk("stall_fin", 32'(bus.fetch_finish_o), 32'd0);
                    tick();
                    chk("stall_hold_y10", ypix(10, 0), 32'hA3A2A1A0);
                end
                bus.data_valid_i = 1'b1;
            end
            chk("addr", bus.fetch_addr_o, base + 32'(k));
            chk("fin_low", 32'(bus.fetch_finish_o), 32'd0);
            tick();
        end
        chk("fin_high", 32'(bus.fetch_finish_o), 32'd1);
    endtask

    initial begin
        int fin_cnt;
        bus.fetch_start_i = 1'b0;
        bus.data_valid_i  = 1'b0;
        bus.fetch_mb_x_i  = 6'd0;
        bus.fetch_mb_y_i  = 6'd0;
        repeat (2) tick();
        chk("rst_addr", bus.fetch_addr_o, 32'd0);
        chk("rst_fin", 32'(bus.fetch_finish_o), 32'd0);
        chk("rst_y", 32'(|bus.matrixY_o), 32'd0);
        chk("rst_u", 32'(|bus.matrixU_o), 32'd0);
        chk("rst_v", 32'(|bus.matrixV_o), 32'd0);

        rst = 1'b1;
        bus.data_valid_i  = 1'b1;
        bus.fetch_start_i = 1'b1;
        run(32'd0, -1, 0, 1'b0);
        tick();
        chk("fin_once", 32'(bus.fetch_finish_o), 32'd0);
        chk("y0_0", ypix(0, 0), 32'h03020100);
        chk("y15_12", ypix(15, 12), 32'hFFFEFDFC);
        chk("u7_4", upix(7, 4), 32'h3F3E3D3C);
        chk("v0_0", vpix(0, 0), 32'h43424140);

        bus.fetch_mb_x_i  = 6'd2;
        bus.fetch_mb_y_i  = 6'd1;
        bus.fetch_start_i = 1'b1;
        run(32'd2304, 40, 3, 1'b0);
        chk("st_y0_0", ypix(0, 0), 32'h03020100);
        chk("st_y10_0", ypix(10, 0), 32'hA3A2A1A0);
        chk("st_y15_12", ypix(15, 12), 32'hFFFEFDFC);
        chk("st_u7_4", upix(7, 4), 32'h3F3E3D3C);
        chk("st_v0_0", vpix(0, 0), 32'h43424140);
        tick();

        bus.fetch_mb_x_i  = 6'd0;
        bus.fetch_mb_y_i  = 6'd0;
        bus.fetch_start_i = 1'b1;
        run(32'd0, -1, 0, 1'b1);
        bus.fetch_mb_x_i = 6'd1;
        bus.fetch_mb_y_i = 6'd0;
        tick();
        chk("relaunch_idle_fin", 32'(bus.fetch_finish_o), 32'd0);
        chk("relaunch_idle_addr", bus.fetch_addr_o, 32'd0);
        run(32'd96, -1, 0, 1'b0);
        chk("mb10_y0_0", ypix(0, 0), 32'h83828180);
        chk("mb10_v0_0", vpix(0, 0), 32'hC3C2C1C0);
        tick();

        bus.fetch_mb_x_i  = 6'd3;
        bus.fetch_mb_y_i  = 6'd0;
        bus.fetch_start_i = 1'b1;
        tick();
        bus.fetch_start_i = 1'b0;
        repeat (50) tick();
        chk("mid_addr", bus.fetch_addr_o, 32'd338);
        rst = 1'b0;
        tick();
        chk("mid_rst_addr", bus.fetch_addr_o, 32'd0);
        chk("mid_rst_fin", 32'(bus.fetch_finish_o), 32'd0);
        chk("mid_rst_y", 32'(|bus.matrixY_o), 32'd0);
        chk("mid_rst_u", 32'(|bus.matrixU_o), 32'd0);
        chk("mid_rst_v", 32'(|bus.matrixV_o), 32'd0);
        rst = 1'b1;
        fin_cnt = 0;
        repeat (100) begin
            tick();
            fin_cnt += int'(bus.fetch_finish_o);
        end
        chk("mid_no_fin", 32'(fin_cnt), 32'd0);
        chk("mid_idle_addr", bus.fetch_addr_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
